// File: rtl/sr_pkg.sv
// sr_pkg: ALU command encodings, flag indices and status types for the status register unit
package sr_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] sr_flags_t;

    function automatic logic isSubCmd(input logic [3:0] cmd);
        return cmd == EXE_SUB || cmd == EXE_SBC;
    endfunction

endpackage

// File: rtl/status_register_unit_flag_alu.sv
// flag_alu: combinational EXE ALU producing the result and N,Z,C,V flags
module flag_alu
    import sr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    input  logic             vIn,
    output logic [WIDTH-1:0] res,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             flagsValid
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bOp;
    logic             carry0;
    logic             isSub;

    always_comb begin
        isSub = isSubCmd(cmd);
        bOp = isSub ? ~b : b;
        // ADC/SBC take the committed carry; plain SUB is a + ~b + 1
        carry0 = (cmd == EXE_ADC || cmd == EXE_SBC) ? cIn : isSub;
        sum = {1'b0, a} + {1'b0, bOp} + {{WIDTH{1'b0}}, carry0};
        res = '0;
        c = cIn;
        v = vIn;
        flagsValid = 1'b1;
        case (cmd)
            EXE_MOV: res = b;
            EXE_MVN: res = ~b;
            EXE_AND: res = a & b;
            EXE_ORR: res = a | b;
            EXE_EOR: res = a ^ b;
            EXE_ADD, EXE_ADC: begin
                res = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            EXE_SUB, EXE_SBC: begin
                res = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            default: flagsValid = 1'b0;
        endcase
        n = res[WIDTH-1];
        z = res == '0;
    end

endmodule

// File: rtl/status_register_unit.sv
// status_register_unit: architectural NZCV register with ALU flag update, bypass, hazard and exception shadow
module status_register_unit
    import sr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exe_valid,
    input  logic [3:0]       exe_cmd,
    input  logic             exe_s,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             stall,
    input  logic             flush,
    input  logic             sr_wr_en,
    input  logic [3:0]       sr_wr_data,
    input  logic             exc_enter,
    input  logic             exc_return,
    input  logic             id_uses_sr,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       status_reg,
    output logic [3:0]       status_fwd,
    output logic             sr_hazard
);

    sr_flags_t statusQ;
    sr_flags_t shadowQ;
    sr_flags_t aluFlags;
    sr_flags_t nextStatus;
    logic      excActive;
    logic      n, z, c, v, flagsValid;
    logic      retEff;
    logic      aluUpd;

    flag_alu #(.WIDTH(WIDTH)) uAlu (
        .cmd        (exe_cmd),
        .a          (op_a),
        .b          (op_b),
        .cIn        (statusQ[FLAG_C]),
        .vIn        (statusQ[FLAG_V]),
        .res        (alu_result),
        .n          (n),
        .z          (z),
        .c          (c),
        .v          (v),
        .flagsValid (flagsValid)
    );

    always_comb begin
        aluFlags = {n, z, c, v};
        // a return outside an exception is a no-op, so lower priorities still apply
        retEff = exc_return & excActive;
        aluUpd = exe_valid & exe_s & ~flush & flagsValid;
        nextStatus = retEff    ? shadowQ    :
                     exc_enter ? statusQ    :
                     sr_wr_en  ? sr_wr_data :
                     aluUpd    ? aluFlags   : statusQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statusQ   <= '0;
            shadowQ   <= '0;
            excActive <= 1'b0;
        end else if (!stall) begin
            statusQ <= nextStatus;
            if (retEff) begin
                excActive <= 1'b0;
            end else if (exc_enter) begin
                shadowQ   <= statusQ;
                excActive <= 1'b1;
            end
        end
    end

    assign status_reg = statusQ;
    assign status_fwd = nextStatus;
    assign sr_hazard  = id_uses_sr & exe_valid & exe_s & ~flush;

endmodule

// File: tb/tb_status_register_unit.sv
// tb_status_register_unit: directed vector table plus hand sequences for stall, exceptions and reset
module tb_status_register_unit;
    import sr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_valid, exe_s, stall, flush, sr_wr_en, exc_enter, exc_return, id_uses_sr;
    logic [3:0]  exe_cmd, sr_wr_data;
    logic [31:0] op_a, op_b;
    logic [31:0] alu_result;
    logic [3:0]  status_reg, status_fwd;
    logic        sr_hazard;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    status_register_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .exe_cmd(exe_cmd), .exe_s(exe_s),
        .op_a(op_a), .op_b(op_b), .stall(stall), .flush(flush), .sr_wr_en(sr_wr_en),
        .sr_wr_data(sr_wr_data), .exc_enter(exc_enter), .exc_return(exc_return),
        .id_uses_sr(id_uses_sr), .alu_result(alu_result), .status_reg(status_reg),
        .status_fwd(status_fwd), .sr_hazard(sr_hazard)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        valid;
        logic        s;
        logic        fl;
        logic        wr;
        logic [3:0]  wd;
        logic [31:0] expRes;
        logic [3:0]  expSr;
        logic        expHaz;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic [3:0] cmd, logic [31:0] a, logic [31:0] b, logic valid, logic s,
                                logic fl, logic wr, logic [3:0] wd, logic [31:0] er, logic [3:0] es, logic eh);
        vec_t t;
        t.cmd = cmd; t.a = a; t.b = b; t.valid = valid; t.s = s; t.fl = fl; t.wr = wr; t.wd = wd;
        t.expRes = er; t.expSr = es; t.expHaz = eh;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        exe_valid = 0; exe_cmd = 4'b0000; exe_s = 0; op_a = '0; op_b = '0; stall = 0; flush = 0;
        sr_wr_en = 0; sr_wr_data = 4'b0000; exc_enter = 0; exc_return = 0; id_uses_sr = 1;
    endtask

    task automatic adds7f();
        exe_valid = 1; exe_cmd = EXE_ADD; exe_s = 1; op_a = 32'h7FFF_FFFF; op_b = 32'h1;
    endtask

    initial begin
        vecs[0]  = mk(EXE_ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 0, 0, 4'h0, 32'h8000_0000, 4'b1001, 1);
        vecs[1]  = mk(EXE_SUB, 32'h5, 32'h5, 1, 1, 0, 0, 4'h0, 32'h0, 4'b0110, 1);
        vecs[2]  = mk(EXE_SBC, 32'h0, 32'h0, 1, 1, 0, 0, 4'h0, 32'h0, 4'b0110, 1);
        vecs[3]  = mk(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 1, 4'b0011, 32'h0, 4'b0011, 0);
        vecs[4]  = mk(EXE_AND, 32'h0, 32'hDEAD_BEEF, 1, 1, 0, 0, 4'h0, 32'h0, 4'b0111, 1);
        vecs[5]  = mk(EXE_AND, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0, 0, 4'h0, 32'h8000_0000, 4'b0111, 0);
        vecs[6]  = mk(EXE_ORR, 32'h8000_0000, 32'h1, 1, 1, 0, 0, 4'h0, 32'h8000_0001, 4'b1011, 1);
        vecs[7]  = mk(EXE_EOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 0, 4'h0, 32'h0, 4'b0111, 1);
        vecs[8]  = mk(EXE_MVN, 32'h0, 32'h0, 1, 1, 0, 0, 4'h0, 32'hFFFF_FFFF, 4'b1011, 1);
        vecs[9]  = mk(EXE_SUB, 32'h0, 32'h1, 1, 1, 0, 0, 4'h0, 32'hFFFF_FFFF, 4'b1000, 1);
        vecs[10] = mk(EXE_ADC, 32'h1, 32'h1, 1, 1, 0, 0, 4'h0, 32'h2, 4'b0000, 1);
        vecs[11] = mk(EXE_ADD, 32'hFFFF_FFFF, 32'h1, 1, 1, 0, 0, 4'h0, 32'h0, 4'b0110, 1);
        vecs[12] = mk(EXE_ADC, 32'h1, 32'h1, 1, 1, 0, 0, 4'h0, 32'h3, 4'b0000, 1);
        vecs[13] = mk(EXE_SUB, 32'h8000_0000, 32'h1, 1, 1, 0, 0, 4'h0, 32'h7FFF_FFFF, 4'b0011, 1);
        vecs[14] = mk(4'b1111, 32'h5, 32'h5, 1, 1, 0, 0, 4'h0, 32'h0, 4'b0011, 1);
        vecs[15] = mk(EXE_ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 1, 0, 4'h0, 32'h8000_0000, 4'b0011, 0);
        vecs[16] = mk(EXE_MOV, 32'h0, 32'h0, 1, 1, 0, 0, 4'h0, 32'h0, 4'b0111, 1);
        vecs[17] = mk(EXE_SBC, 32'h5, 32'h3, 1, 1, 0, 0, 4'h0, 32'h2, 4'b0010, 1);
        vecs[18] = mk(EXE_SBC, 32'h3, 32'h5, 1, 1, 0, 0, 4'h0, 32'hFFFF_FFFE, 4'b1000, 1);
        vecs[19] = mk(EXE_SBC, 32'h5, 32'h3, 1, 1, 0, 0, 4'h0, 32'h1, 4'b0010, 1);

        idle();
        rst_n = 0;
        #12;
        chk("reset_status", {28'h0, status_reg}, 32'h0);
        chk("reset_fwd", {28'h0, status_fwd}, 32'h0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle();
            exe_cmd = vecs[i].cmd; op_a = vecs[i].a; op_b = vecs[i].b; exe_valid = vecs[i].valid;
            exe_s = vecs[i].s; flush = vecs[i].fl; sr_wr_en = vecs[i].wr; sr_wr_data = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d_result", i), alu_result, vecs[i].expRes);
            chk($sformatf("vec%0d_fwd", i), {28'h0, status_fwd}, {28'h0, vecs[i].expSr});
            chk($sformatf("vec%0d_hazard", i), {31'h0, sr_hazard}, {31'h0, vecs[i].expHaz});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_status", i), {28'h0, status_reg}, {28'h0, vecs[i].expSr});
        end

        // stall holds status while the bypass shows the pending ADDS flags
        @(negedge clk);
        idle();
        adds7f();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_status", i), {28'h0, status_reg}, 32'h2);
            chk($sformatf("stall%0d_fwd", i), {28'h0, status_fwd}, 32'h9);
        end
        @(negedge clk);
        stall = 0;
        @(posedge clk);
        #1;
        chk("stall_release_status", {28'h0, status_reg}, 32'h9);

        // exception save / overwrite / restore
        @(negedge clk);
        idle();
        sr_wr_en = 1; sr_wr_data = 4'b1010;
        @(posedge clk); #1;
        chk("exc_pre_status", {28'h0, status_reg}, 32'hA);
        @(negedge clk);
        idle();
        exc_enter = 1;
        @(posedge clk); #1;
        chk("exc_enter_status", {28'h0, status_reg}, 32'hA);
        @(negedge clk);
        idle();
        sr_wr_en = 1; sr_wr_data = 4'b0001;
        @(posedge clk); #1;
        chk("exc_write_status", {28'h0, status_reg}, 32'h1);
        @(negedge clk);
        idle();
        exc_return = 1;
        #1;
        chk("exc_return_fwd", {28'h0, status_fwd}, 32'hA);
        @(posedge clk); #1;
        chk("exc_return_status", {28'h0, status_reg}, 32'hA);

        // a second return with no active exception must not restore the shadow
        @(negedge clk);
        idle();
        sr_wr_en = 1; sr_wr_data = 4'b0100;
        @(posedge clk); #1;
        @(negedge clk);
        idle();
        exc_return = 1;
        @(posedge clk); #1;
        chk("exc_return_inactive", {28'h0, status_reg}, 32'h4);

        // asynchronous reset in the middle of an ADDS
        @(negedge clk);
        idle();
        adds7f();
        @(posedge clk); #1;
        chk("pre_reset_adds", {28'h0, status_reg}, 32'h9);
        #2;
        rst_n = 0;
        #1;
        chk("async_reset_status", {28'h0, status_reg}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        idle();
        exc_return = 1;
        @(posedge clk); #1;
        chk("reset_clears_exc_active", {28'h0, status_reg}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
